// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared depth default, pointer width and buffer entry type
// for the posted-write store buffer.
package store_buffer_pkg;

   localparam int unsigned SB_DEPTH = 4;
   localparam int unsigned PTR_W    = $clog2(SB_DEPTH);

   // One buffered store: word address (byte address bits 31:2) and data.
   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] data;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU data-port signals and the RAM-side master signals of
// the store buffer. The slave modport is the store buffer itself; the master
// modport is the environment (CPU plus data RAM) around it.
interface store_buffer_if;

   logic        MemRd;
   logic        MemWr;
   logic [31:0] Addr;
   logic [31:0] WrData;
   logic [31:0] RdData;
   logic        Stall;
   logic        Empty;

   logic        RamMemRd;
   logic        RamMemWr;
   logic [31:0] RamAddr;
   logic [31:0] RamWrData;
   logic [31:0] RamRdData;

   modport master (
      output MemRd, MemWr, Addr, WrData, RamRdData,
      input  RdData, Stall, Empty, RamMemRd, RamMemWr, RamAddr, RamWrData
   );

   modport slave (
      input  MemRd, MemWr, Addr, WrData, RamRdData,
      output RdData, Stall, Empty, RamMemRd, RamMemWr, RamAddr, RamWrData
   );

endinterface

// File: rtl/store_buffer_match.sv
// store_buffer_match: address search over the buffered stores. Reports
// whether any valid entry holds the given word address and returns the data
// of the youngest such entry.
module store_buffer_match
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0] entries,
   input  logic      [DEPTH-1:0] valid,
   input  logic      [AW-1:0]    head,
   input  logic      [29:0]      waddr,
   output logic                  hit,
   output logic      [31:0]      data
);

   logic [AW-1:0] idx;

   // Walk entries oldest (head) to youngest; a later match overwrites an
   // earlier one, giving the same winner as a search downward from tail-1.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head + AW'(k);
         if (valid[idx] && (entries[idx].waddr == waddr)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the CPU data port and the
// word-addressed data RAM. Stores are accepted in one cycle into a circular
// FIFO and drained in order whenever no load owns the RAM port.
// Optional feature macro: STORE_BUFFER_FWD_EN -- when defined, load hits are
// forwarded from the buffer; when undefined, a load hit stalls until the
// matching entries have drained.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH
) (
   input logic           clk,
   input logic           reset,
   store_buffer_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   sb_entry_t [DEPTH-1:0] entries;
   logic [AW-1:0]         head;
   logic [AW-1:0]         tail;
   logic [CW-1:0]         count;

   logic [DEPTH-1:0]      valid;
   logic [AW-1:0]         age;
   logic                  match_any;
   logic                  hit;
   logic [31:0]           hit_data;
   logic                  hit_stall;
   logic                  full_stall;
   logic                  stall;
   logic                  ram_load;
   logic                  drain_en;
   logic                  accept;

   // An entry is live when its distance from head is below the count.
   always_comb begin
      valid = '0;
      age   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         age      = AW'(i) - head;
         valid[i] = ({1'b0, age} < count);
      end
   end

   store_buffer_match #(
      .DEPTH (DEPTH)
   ) u_match (
      .entries (entries),
      .valid   (valid),
      .head    (head),
      .waddr   (bus.Addr[31:2]),
      .hit     (match_any),
      .data    (hit_data)
   );

   assign hit = bus.MemRd && match_any;

`ifdef STORE_BUFFER_FWD_EN
   assign hit_stall = 1'b0;
`else
   logic unused_hit_data;
   assign hit_stall       = hit;
   assign unused_hit_data = ^hit_data;
`endif

   // Port arbitration: a RAM load wins over draining; the store is taken
   // unless the buffer is full with no drain, or a non-forwarded hit stalls.
   always_comb begin
      ram_load   = bus.MemRd && !hit;
      drain_en   = (count != '0) && !ram_load;
      full_stall = bus.MemWr && (count == CW'(DEPTH)) && !drain_en;
      stall      = hit_stall || full_stall;
      accept     = bus.MemWr && !stall;

      bus.RdData = '0;
      if (ram_load) begin
         bus.RdData = bus.RamRdData;
      end
`ifdef STORE_BUFFER_FWD_EN
      else if (hit) begin
         bus.RdData = hit_data;
      end
`endif

      bus.RamMemRd  = ram_load;
      bus.RamMemWr  = drain_en;
      bus.RamAddr   = '0;
      bus.RamWrData = '0;
      if (ram_load) begin
         bus.RamAddr = bus.Addr;
      end else if (drain_en) begin
         bus.RamAddr   = {entries[head].waddr, 2'b00};
         bus.RamWrData = entries[head].data;
      end

      bus.Stall = stall;
      bus.Empty = (count == '0);
   end

   // FIFO state: push at tail on accept, pop at head on drain; reset discards
   // every buffered store so none reaches the RAM afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entries <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
      end else begin
         if (accept) begin
            entries[tail].waddr <= bus.Addr[31:2];
            entries[tail].data  <= bus.WrData;
            tail                <= tail + 1'b1;
         end
         if (drain_en) begin
            head <= head + 1'b1;
         end
         count <= count + CW'(accept) - CW'(drain_en);
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: self-checking bench for store_buffer. A queue-based model
// of the buffer plus a reference RAM image predict every output each cycle.
// Expectations follow STORE_BUFFER_FWD_EN the same way the design does.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk;
   logic reset;
   store_buffer_if sbif ();

   store_buffer #(
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sbif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM behind the buffer (256 words, byte address bits 9:2)
   logic [31:0] ram [0:255];
   logic        ram_clear;
   logic [63:0] wr_log [$];

   always_comb sbif.RamRdData = sbif.RamMemRd ? ram[sbif.RamAddr[9:2]] : 32'hBAD0_0000;

   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'h5A5A_0000 | 32'(i);
      end else if (sbif.RamMemWr) begin
         ram[sbif.RamAddr[9:2]] <= sbif.RamWrData;
         wr_log.push_back({sbif.RamAddr, sbif.RamWrData});
      end
   end

   // Reference model
   logic [31:0] ref_mem [0:255];
   logic [29:0] q_addr [$];
   logic [31:0] q_data [$];
   logic [99:0] obs_v;
   logic [99:0] exp_v;
   int          checks;
   int          failures;

   logic [31:0] pool [8] = '{32'h0000_0040, 32'h0000_0044, 32'h0000_0048, 32'h0000_0100,
                             32'h8000_0040, 32'h0000_03FC, 32'h0000_0000, 32'h0000_0010};

   // One cycle: drive inputs after the edge, sample at the falling edge,
   // predict outputs from the queue, then advance the model past the edge.
   task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      logic        hit, e_rrd, e_drain, e_stall, e_hstall;
      logic [31:0] yd, e_rd, e_ra, e_rw;
      int          n;
      @(posedge clk);
      #1;
      sbif.MemRd  = rd;
      sbif.MemWr  = wr;
      sbif.Addr   = a;
      sbif.WrData = d;
      @(negedge clk);
      n   = q_addr.size();
      hit = 1'b0;
      yd  = '0;
      if (rd) begin
         for (int i = 0; i < n; i++) begin
            if (q_addr[i] == a[31:2]) begin
               hit = 1'b1;
               yd  = q_data[i];
            end
         end
      end
`ifdef STORE_BUFFER_FWD_EN
      e_hstall = 1'b0;
`else
      e_hstall = hit;
`endif
      e_rrd   = rd && !hit;
      e_drain = (n != 0) && !e_rrd;
      e_stall = e_hstall || (wr && n == int'(DEPTH) && !e_drain);
      e_rd    = '0;
      if (e_rrd) e_rd = ref_mem[a[9:2]];
`ifdef STORE_BUFFER_FWD_EN
      else if (hit) e_rd = yd;
`endif
      e_ra = '0;
      e_rw = '0;
      if (e_rrd) e_ra = a;
      else if (e_drain) begin
         e_ra = {q_addr[0], 2'b00};
         e_rw = q_data[0];
      end
      exp_v = {e_stall, (n == 0), e_rrd, e_drain, e_ra, e_rw, e_rd};
      obs_v = {sbif.Stall, sbif.Empty, sbif.RamMemRd, sbif.RamMemWr,
               sbif.RamAddr, sbif.RamWrData, sbif.RdData};
      if (e_drain) begin
         ref_mem[q_addr[0][7:0]] = q_data[0];
         void'(q_addr.pop_front());
         void'(q_data.pop_front());
      end
      if (wr && !e_stall) begin
         q_addr.push_back(a[31:2]);
         q_data.push_back(d);
      end
   endtask

   task automatic settle(input string name);
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         step(1'b0, 1'b0, 32'h0, 32'h0);
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL %s_drain[%0d] got=%h exp=%h", name, i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_reset();
      int base;
      // Power-on reset values
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({sbif.Empty, sbif.Stall, sbif.RamMemWr, sbif.RamMemRd, sbif.RamAddr, sbif.RamWrData, sbif.RdData}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
         failures++;
         $display("FAIL reset_values got=%b/%b/%b/%b/%h/%h/%h exp=1/0/0/0/0/0/0", sbif.Empty, sbif.Stall,
                  sbif.RamMemWr, sbif.RamMemRd, sbif.RamAddr, sbif.RamWrData, sbif.RdData);
      end
      #9 reset = 1'b1;
      #1 ram_clear = 1'b0;
      // Three entries via load-miss+store cycles, one drains, then reset
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hC000_0000 + 32'(i));
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_fill[%0d] got=%h exp=%h", i, obs_v, exp_v);
         end
      end
      step(1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin
         failures++;
         $display("FAIL reset_drain1 got=%h exp=%h", obs_v, exp_v);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({sbif.Empty, sbif.RamMemWr} !== 2'b10) begin
         failures++;
         $display("FAIL reset_mid Empty/RamMemWr got=%b%b exp=10", sbif.Empty, sbif.RamMemWr);
      end
      q_addr.delete();
      q_data.delete();
      base = wr_log.size();
      @(posedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 32'h0, 32'h0);
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_after[%0d] got=%h exp=%h", i, obs_v, exp_v);
         end
      end
      checks++;
      if (wr_log.size() !== base) begin
         failures++;
         $display("FAIL reset_discard writes got=%0d exp=%0d", wr_log.size(), base);
      end
   endtask

   task automatic test_store_burst();
      int base;
      base = wr_log.size();
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 32'(4 * i), 32'hA0 + 32'(i));
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL burst[%0d] got=%h exp=%h", i, obs_v, exp_v);
         end
      end
      settle("burst");
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (wr_log.size() <= base + k || wr_log[base + k] !== {32'(4 * k), 32'hA0 + 32'(k)}) begin
            failures++;
            $display("FAIL burst_order[%0d] got=%h exp=%h", k,
                     (wr_log.size() > base + k) ? wr_log[base + k] : 64'h0, {32'(4 * k), 32'hA0 + 32'(k)});
         end
      end
   endtask

   task automatic test_forwarding();
      step(1'b0, 1'b1, 32'h100, 32'hB0);
      step(1'b1, 1'b1, 32'h40, 32'h11);
      checks++;
      if (obs_v !== exp_v) begin
         failures++;
         $display("FAIL fwd_setup1 got=%h exp=%h", obs_v, exp_v);
      end
      step(1'b1, 1'b1, 32'h40, 32'h22);
      checks++;
      if (obs_v !== exp_v) begin
         failures++;
         $display("FAIL fwd_setup2 got=%h exp=%h", obs_v, exp_v);
      end
`ifndef STORE_BUFFER_FWD_EN
      checks++;
      if (obs_v[99] !== 1'b1) begin
         failures++;
         $display("FAIL nofwd_hit_stall got=%b exp=1", obs_v[99]);
      end
`endif
      step(1'b1, 1'b0, 32'h40, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin
         failures++;
         $display("FAIL fwd_load got=%h exp=%h", obs_v, exp_v);
      end
`ifdef STORE_BUFFER_FWD_EN
      checks++;
      if ({obs_v[97], obs_v[31:0]} !== {1'b0, 32'h22}) begin
         failures++;
         $display("FAIL fwd_youngest RamMemRd/RdData got=%b/%h exp=0/00000022", obs_v[97], obs_v[31:0]);
      end
`endif
      settle("fwd");
   endtask

   task automatic test_no_forward();
      step(1'b0, 1'b1, 32'h40, 32'hBEEF);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h40, 32'h0);
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL hitload[%0d] got=%h exp=%h", i, obs_v, exp_v);
         end
      end
      checks++;
      if (obs_v[31:0] !== 32'hBEEF) begin
         failures++;
         $display("FAIL hitload_data got=%h exp=0000beef", obs_v[31:0]);
      end
      settle("hitload");
   endtask

   task automatic test_full_plus_load();
      for (int i = 0; i < 6; i++) begin
         // four load-miss+store fills, a blocked store, then the store alone
         step(i < 5, 1'b1, 32'h280 + 32'(4 * i), 32'hF000_0000 + 32'(i));
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL full[%0d] got=%h exp=%h", i, obs_v, exp_v);
         end
      end
      settle("full");
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 20; i++) begin
         step(1'b0, (i % 2) == 0, 32'h300 + 32'(2 * i), $urandom);
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL wrap[%0d] got=%h exp=%h", i, obs_v, exp_v);
         end
      end
      settle("wrap");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 55,
              pool[$urandom_range(0, 7)], $urandom);
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL random[%0d] got=%h exp=%h", i, obs_v, exp_v);
         end
      end
      settle("random");
   endtask

   task automatic test_ram_contents();
      int bad;
      int first;
      bad   = 0;
      first = -1;
      for (int i = 0; i < 256; i++) begin
         if (ram[i] !== ref_mem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL ram_contents words_differing=%0d first_word=%0d got=%h exp=%h",
                  bad, first, ram[first], ref_mem[first]);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      ram_clear   = 1'b1;
      sbif.MemRd  = 1'b0;
      sbif.MemWr  = 1'b0;
      sbif.Addr   = '0;
      sbif.WrData = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h5A5A_0000 | 32'(i);
      test_reset();
      test_store_burst();
      test_forwarding();
      test_no_forward();
      test_full_plus_load();
      test_wrap();
      test_random();
      test_ram_contents();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the CPU data-memory port and the word-addressed data RAM. It accepts stores in one cycle and drains them into the RAM in order whenever the RAM port is free. Loads take priority over draining and, when forwarding is compiled in, see buffered data. It sits directly upstream of the data RAM and presents a RAM-style master interface to it: MemRd, MemWr, Addr, WrData, with RdData returned combinationally.

## Interface
- DEPTH, 4: number of buffered stores; power of two, at least 2.
- clk  in  1  system clock, all state on the rising edge.
- reset  in  1  asynchronous, active-low; clears all buffer state.
- MemRd  in  1  CPU load request.
- MemWr  in  1  CPU store request.
- Addr  in  32  CPU byte address, word-aligned; only Addr[31:2] is used.
- WrData  in  32  CPU store data.
- RdData  out  32  CPU load data, combinational.
- Stall  out  1  CPU must hold its request and retry next cycle.
- Empty  out  1  no buffered stores.
- RamMemRd  out  1  RAM read enable.
- RamMemWr  out  1  RAM write enable.
- RamAddr  out  32  RAM byte address.
- RamWrData  out  32  RAM write data.
- RamRdData  in  32  RAM read data, combinational.

## Operation
- State: a circular FIFO of DEPTH entries {word address Addr[31:2], data}, plus head pointer, tail pointer and count. Count width is clog2(DEPTH)+1.
- hit: MemRd=1 and at least one valid entry has address equal to Addr[31:2], comparing the full 30 bits. The youngest matching entry wins.
- Load handling:
  - With forwarding (see Configuration), a hit sets RdData to the youngest matching entry's data. The RAM is not read (RamMemRd=0).
  - A load miss drives RamMemRd=1, RamAddr=Addr, and RdData=RamRdData.
  - With MemRd=0, RdData=0.
- Drain: drain_en = (count≠0) and not ram_load. ram_load means a load currently using the RAM port.
  - When drain_en=1: RamMemWr=1, RamAddr={head address,2'b00}, RamWrData=head data. Head advances at the clock edge.
  - When RamMemWr=0 and RamMemRd=0: RamAddr=0 and RamWrData=0.
- Store accept: accept = MemWr and not Stall.
  - On accept, the entry is written at tail and tail advances.
  - Count is updated as +accept −drain_en, so simultaneous push and pop leaves it unchanged.
- Stall sources:
  - MemWr=1 with count=DEPTH and drain_en=0. This is only reachable when MemRd and MemWr are asserted together.
  - The no-forwarding hit case (see Configuration).
- MemRd and MemWr together: the load is served first and the store is accepted unless it stalls. The CPU never does this; the block still behaves as stated.
- Pointers wrap modulo DEPTH.
- Reset mid-operation: buffered stores are discarded and are not written to the RAM.

## Timing
- Reset values: Empty=1, Stall=0, RamMemWr=0, RamMemRd=0, RamAddr=0, RamWrData=0, RdData=0 (with MemRd=0). Count, head and tail are 0.
- Load latency is 0 cycles: RdData is combinational from the inputs and the buffer state.
- A store accepted at edge N is visible to forwarding from cycle N+1 onward.
- A store accepted at edge N can reach the RAM no earlier than edge N+1.
- Drain throughput is one entry per cycle.
- Full buffer plus a store with no load: the drain and the push happen on the same edge, so there is no stall.
- Empty is registered-state derived and is (count==0).

## Configuration
- STORE_BUFFER_FWD_EN defined:
  - Load hits are forwarded from the buffer.
  - A hit never stalls, and the drain continues during the hit.
- STORE_BUFFER_FWD_EN undefined:
  - A load hit asserts Stall=1 and RdData=0; RamMemRd is 0.
  - The drain proceeds on the RAM port.
  - Stall holds until no matching entry remains. The load then completes from the RAM.

## Structure
- Shared package store_buffer_pkg holds:
  - the default DEPTH;
  - localparam PTR_W=clog2(DEPTH);
  - the entry typedef {logic [29:0] waddr; logic [31:0] data}.
- One sub-module, store_buffer_match. It takes the entry array, valid mask, head and Addr[31:2], and returns hit plus the youngest-match data. It performs an age-ordered comparison starting from tail−1.

## Test plan
- Reset: assert reset=0 mid-drain with 3 entries → Empty=1, RamMemWr=0, and none of the remaining entries are written to the RAM afterwards.
- Store burst: 6 back-to-back stores with DEPTH=4, addresses 0x00..0x14, data 0xA0..0xA5 → Stall never asserted; the RAM receives the data in order, one write per cycle starting 1 cycle after the first store.
- Forwarding (FWD_EN): store 0x11 then 0x22 to 0x40, hold the drain with loads to 0x100, then load 0x40 → RdData=0x22 (youngest match) and RamMemRd=0.
- No forwarding: store 0xBEEF to 0x40, then load 0x40 the next cycle → Stall=1 for 1 cycle while the entry drains; then RdData=0xBEEF read from the RAM.
- Full plus load: fill 4 entries while loading a miss address each cycle, then assert MemRd and MemWr together → Stall=1 and the store is not accepted; release the load → the store is accepted.
- Wrap-around: 10 alternating store/idle cycles with DEPTH=4 → the pointers wrap and the RAM contents match all 10 stores.
